// File: rtl/trng_pkg.sv
// Shared constants and types for the TRNG vector buffer.
package trng_pkg;

  localparam int VEC_W       = 8;
  localparam int SYNC_STAGES = 2;

  // Counter must be able to hold the value VEC_W itself.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

  localparam int CNT_W = cnt_width(VEC_W);

  // Which half of a debiasing pair the next accepted sample belongs to.
  typedef enum logic {
    PH_FIRST  = 1'b0,
    PH_SECOND = 1'b1
  } vn_phase_e;

endpackage

// File: rtl/trng_vector_buffer_ring_osc.sv
// Gated ring oscillator: NAND first stage gated by en, then STAGES-1 inverters closed in a loop.
// The unit delays let the loop run in simulation; synthesis ignores them.
module ring_osc #(
  parameter int STAGES = 5
) (
  input  logic en,
  output logic out
);

  (* keep = "true", dont_touch = "true" *) logic w_stage [STAGES];

  assign #1 w_stage[0] = ~(en & w_stage[STAGES-1]);

  for (genvar gi = 1; gi < STAGES; gi++) begin : g_inv
    assign #1 w_stage[gi] = ~w_stage[gi-1];
  end

  assign out = en & w_stage[STAGES-1];

endmodule

// File: rtl/trng_vector_buffer.sv
// Entropy collection: ring oscillator (or ext_bit) -> synchroniser -> WIDTH-bit vector with valid/consume.
// Define VON_NEUMANN_EN to debias accepted samples in pairs (10 -> 1, 01 -> 0, 00/11 dropped).
module trng_vector_buffer
  import trng_pkg::*;
#(
  parameter int STAGES = 5,
  parameter int WIDTH  = VEC_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req,
  input  logic             use_ext,
  input  logic             ext_bit,
  output logic [WIDTH-1:0] vector,
  output logic             vector_valid
);

  localparam int CW = cnt_width(WIDTH);

  logic                   r_en;
  logic                   w_osc_en;
  logic                   w_osc_out;
  logic                   w_src;
  logic [SYNC_STAGES-1:0] r_src_sync;
  logic [SYNC_STAGES-1:0] r_src_vld;
  logic [SYNC_STAGES-1:0] r_req_sync;
  logic                   r_req_prev;
  logic                   w_req_rise;
  logic                   w_sample;
  logic                   w_sample_vld;
  logic                   w_bit;
  logic                   w_bit_vld;
  logic [CW-1:0]          r_cnt;
  logic [WIDTH-2:0]       r_shift;
  logic [WIDTH-1:0]       w_shift_next;
  logic [WIDTH-1:0]       r_vector;
  logic                   r_valid;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_en <= 1'b0;
    end else begin
      r_en <= 1'b1;
    end
  end

  assign w_osc_en = r_en & ~use_ext;

  (* keep = "true", dont_touch = "true" *)
  ring_osc #(
    .STAGES(STAGES)
  ) u_ring (
    .en (w_osc_en),
    .out(w_osc_out)
  );

  assign w_src = use_ext ? ext_bit : w_osc_out;

  // Data, its valid flag and the request all travel through matching flop chains.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_src_sync <= '0;
      r_src_vld  <= '0;
      r_req_sync <= '0;
      r_req_prev <= 1'b0;
    end else begin
      r_src_sync <= {r_src_sync[SYNC_STAGES-2:0], w_src};
      r_src_vld  <= {r_src_vld[SYNC_STAGES-2:0], r_en};
      r_req_sync <= {r_req_sync[SYNC_STAGES-2:0], req};
      r_req_prev <= r_req_sync[SYNC_STAGES-1];
    end
  end

  assign w_sample     = r_src_sync[SYNC_STAGES-1];
  assign w_sample_vld = r_src_vld[SYNC_STAGES-1] & ~r_valid;
  assign w_req_rise   = r_req_sync[SYNC_STAGES-1] & ~r_req_prev;

`ifdef VON_NEUMANN_EN
  vn_phase_e r_phase;
  logic      r_first;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_phase <= PH_FIRST;
      r_first <= 1'b0;
    end else if (r_valid && w_req_rise) begin
      r_phase <= PH_FIRST;
    end else if (w_sample_vld) begin
      if (r_phase == PH_FIRST) begin
        r_first <= w_sample;
        r_phase <= PH_SECOND;
      end else begin
        r_phase <= PH_FIRST;
      end
    end
  end

  // A differing pair emits its first sample.
  assign w_bit_vld = w_sample_vld && (r_phase == PH_SECOND) && (r_first != w_sample);
  assign w_bit     = r_first;
`else
  assign w_bit_vld = w_sample_vld;
  assign w_bit     = w_sample;
`endif

  // Only WIDTH-1 bits are kept; the last bit completes the vector directly.
  assign w_shift_next = {r_shift, w_bit};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_shift  <= '0;
      r_vector <= '0;
      r_valid  <= 1'b0;
    end else if (r_valid) begin
      if (w_req_rise) begin
        r_valid <= 1'b0;
        r_cnt   <= '0;
        r_shift <= '0;
      end
    end else if (w_bit_vld) begin
      if (r_cnt == CW'(WIDTH - 1)) begin
        r_vector <= w_shift_next;
        r_valid  <= 1'b1;
        r_cnt    <= '0;
        r_shift  <= '0;
      end else begin
        r_cnt   <= r_cnt + CW'(1);
        r_shift <= w_shift_next[WIDTH-2:0];
      end
    end
  end

  assign vector       = r_vector;
  assign vector_valid = r_valid;

endmodule

// File: tb/tb_trng_vector_buffer.sv
// Self-checking bench for trng_vector_buffer: directed steps plus random traffic against a queue-based model.
module tb_trng_vector_buffer;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req = 1'b0;
  logic         use_ext = 1'b1;
  logic         ext_bit = 1'b0;
  logic [W-1:0] vector;
  logic         vector_valid;

  trng_vector_buffer #(
    .STAGES(5),
    .WIDTH (W)
  ) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .use_ext     (use_ext),
    .ext_bit     (ext_bit),
    .vector      (vector),
    .vector_valid(vector_valid)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Reference model: edge index since reset release, per-edge input history, bit queue.
  int           k;
  bit           src_h[4096];
  bit           known_h[4096];
  bit           req_h[4096];
  bit           m_valid;
  logic [W-1:0] m_vec;
  bit           m_vec_known;
  bit           q[$];
  bit           qk[$];

  int osc_rises = 0;
  always @(posedge u_dut.w_osc_out) osc_rises++;

  initial begin
    #400000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  function automatic bit req_at(input int i);
    return (i < 0) ? 1'b0 : req_h[i];
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp)
    else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    k           = 0;
    m_valid     = 1'b0;
    m_vec       = '0;
    m_vec_known = 1'b1;
    q.delete();
    qk.delete();
  endtask

  // A request rise is seen two edges after req is first sampled high; bits appear two edges after sampling.
  task automatic model_edge();
    bit rise;
    rise = req_at(k - 2) && !req_at(k - 3);
    if (m_valid) begin
      if (rise) begin
        m_valid = 1'b0;
        q.delete();
        qk.delete();
      end
    end else if (k >= 3) begin
      q.push_back(src_h[k-2]);
      qk.push_back(known_h[k-2]);
      if (q.size() == W) begin
        m_vec_known = 1'b1;
        for (int i = 0; i < W; i++) begin
          m_vec[W-1-i] = q[i];
          if (!qk[i]) m_vec_known = 1'b0;
        end
        m_valid = 1'b1;
        q.delete();
        qk.delete();
      end
    end
  endtask

  task automatic tick(input bit nb, input bit nr);
    ext_bit = nb;
    req     = nr;
    @(posedge clk);
    if (rst_n) begin
      src_h[k]   = use_ext ? nb : 1'b0;
      known_h[k] = use_ext;
      req_h[k]   = nr;
      model_edge();
      k++;
    end else begin
      model_reset();
    end
    #1;
    check("valid", 32'(vector_valid), 32'(m_valid));
    if (m_vec_known) check("vector", 32'(vector), 32'(m_vec));
    $display("edge k=%0d rst_n=%0b req=%0b ext=%0b valid=%0b vector=%02h", k, rst_n, nr, nb,
             vector_valid, vector);
  endtask

  function automatic bit rb();
    return 1'($urandom_range(0, 1));
  endfunction

  logic [7:0] pat = 8'hB2;
  bit         rp[16] = '{1, 1, 0, 0, 1, 1, 1, 0, 1, 1, 1, 1, 1, 1, 1, 1};
  bit         rq;
  int         rises0;

  initial begin
    model_reset();

    // Reset and warm-up
    rst_n = 1'b0;
    repeat (5) tick(1'b0, 1'b0);
    check("rst_vector", 32'(vector), 32'h0);
    check("rst_valid", 32'(vector_valid), 32'h0);

    // Basic capture: bits sampled at E1..E8 are accepted at E3..E10
    rst_n = 1'b1;
    tick(rb(), 1'b0);
    for (int i = 0; i < 8; i++) tick(pat[7-i], 1'b0);
    tick(rb(), 1'b0);
    check("warmup_valid_E9", 32'(vector_valid), 32'h0);
    tick(rb(), 1'b0);
    check("capture_valid_E10", 32'(vector_valid), 32'h1);
    check("capture_vec", 32'(vector), 32'hB2);

    // Hold while full
    repeat (10) tick(rb(), 1'b0);
    check("hold_vec", 32'(vector), 32'hB2);
    check("hold_valid", 32'(vector_valid), 32'h1);

    // Consume, then refill with ones
    tick(1'b1, 1'b1);
    check("req_lat_Er", 32'(vector_valid), 32'h1);
    tick(1'b1, 1'b1);
    check("req_lat_Er1", 32'(vector_valid), 32'h1);
    tick(1'b1, 1'b1);
    check("req_clear_Er2", 32'(vector_valid), 32'h0);
    check("req_keep_vec", 32'(vector), 32'hB2);
    repeat (7) tick(1'b1, 1'b1);
    check("refill_valid_early", 32'(vector_valid), 32'h0);
    tick(1'b1, 1'b1);
    check("refill_valid", 32'(vector_valid), 32'h1);
    check("refill_vec", 32'(vector), 32'hFF);

    // Ignored requests: one rise during collection, one on the completion edge
    tick(rb(), 1'b0);
    tick(rb(), 1'b0);
    for (int i = 0; i < 16; i++) begin
      tick(rb(), rp[i]);
      if (i == 9) check("ign_req_valid_early", 32'(vector_valid), 32'h0);
      if (i == 10) check("ign_req_complete", 32'(vector_valid), 32'h1);
    end
    check("coincident_req_ignored", 32'(vector_valid), 32'h1);

    // Random traffic
    rq = 1'b1;
    repeat (300) begin
      if ($urandom_range(0, 5) == 0) rq = ~rq;
      tick(rb(), rq);
    end

    // Reset mid-operation, then warm-up again
    rst_n = 1'b0;
    repeat (2) tick(rb(), 1'b0);
    check("midrst_vec", 32'(vector), 32'h0);
    check("midrst_valid", 32'(vector_valid), 32'h0);
    rst_n = 1'b1;
    for (int i = 0; i < 11; i++) begin
      tick(rb(), 1'b0);
      if (i == 9) check("rewarm_valid_E9", 32'(vector_valid), 32'h0);
    end
    check("rewarm_valid_E10", 32'(vector_valid), 32'h1);

    // Oscillator path
    rst_n   = 1'b0;
    use_ext = 1'b0;
    repeat (2) tick(1'b0, 1'b0);
    rst_n  = 1'b1;
    rises0 = osc_rises;
    for (int i = 0; i < 11; i++) begin
      tick(1'b0, 1'b0);
      if (i == 9) check("osc_valid_E9", 32'(vector_valid), 32'h0);
    end
    check("osc_valid_E10", 32'(vector_valid), 32'h1);
    check("osc_toggling", 32'((osc_rises - rises0) > 0), 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/trng_vector_buffer.md
# trng_vector_buffer

Entropy-collection block for the TinyTapeout TRNG. It contains a gated ring oscillator as the raw entropy source, synchronises its output into the `clk` domain and shifts sampled bits into an 8-bit vector. It presents the vector to the chip outputs with a valid flag, and a consumer request releases it.

## Interface

Parameters:
- `STAGES`, default 5: inverter count of the ring oscillator; must be odd and ≥3.
- `WIDTH`, default 8: vector width in bits.

Ports:
- `clk`: input, 1 bit. Single system clock.
- `rst_n`: input, 1 bit. Reset, synchronous, active-low.
- `req`: input, 1 bit. Asynchronous consume request (chip pin `ui_in[0]`).
- `use_ext`: input, 1 bit. 1 = sample `ext_bit` instead of the oscillator (test mode).
- `ext_bit`: input, 1 bit. External bit source, asynchronous.
- `vector`: output, `WIDTH` bits. Last completed random vector.
- `vector_valid`: output, 1 bit. `vector` holds an unconsumed vector.

## Operation

- **Enable flop `en`:**
  - Cleared by reset.
  - Set at the first `clk` edge with `rst_n`=1 (edge E0).
  - Stays set until the next reset.
- **Oscillator:** enabled when `en`=1 and `use_ext`=0; output forced to 0 when disabled.
- **Source mux:**
  - Selects `use_ext ? ext_bit : osc_out`.
  - Feeds a 2-flop synchroniser.
  - A matching 2-stage valid pipeline is driven by `en`.
- **Collection:** while `vector_valid`=0 and the pipeline is valid, each synchronised bit is shifted in MSB-first, so the first accepted bit ends in `vector[WIDTH-1]`.
- **Vector completion:**
  - On the edge that accepts bit number `WIDTH`, `vector` loads the full shift value and `vector_valid` is set.
  - The bit counter then returns to 0.
- **Full state:** while `vector_valid`=1, sampling pauses and `vector` is held.
- **Request handling:**
  - `req` passes through a 2-flop synchroniser plus a previous-value flop.
  - A rising edge is detected when synchronised=1 and previous=0.
  - Rising edge while `vector_valid`=1:
    - `vector_valid` clears.
    - The counter and shift register clear.
    - `vector` keeps its old value.
  - Rising edge while `vector_valid`=0: ignored.
- **Simultaneous events:** a request edge on the same edge that completes a vector is ignored, because `vector_valid` was still 0. The vector becomes valid and needs a new `req` edge.
- **Reset mid-collection:** everything clears and the warm-up restarts.

## Timing

- **Reset values:**
  - `vector`=0, `vector_valid`=0.
  - Counter, shift register, synchronisers, request flops and `en` all 0.
- **Startup:**
  - `en` rises at E0.
  - The synchroniser is valid at E2.
  - The first bit is accepted at E3.
  - Without debiasing, `vector_valid` is set at E3+`WIDTH`−1 (E10 for 8 bits).
- **Request latency:** if `req` is first sampled high at edge Er, `vector_valid` clears at Er+2.
- **After a request clear:** the next bit is accepted one edge later. The next vector is valid `WIDTH` edges after the clear (non-debiased).
- **Sampling rate:** one bit per clock, nothing buffered beyond one vector.

## Configuration

- **`VON_NEUMANN_EN` defined:**
  - Accepted samples are grouped into consecutive pairs.
  - Pair 10 yields bit 1; pair 01 yields bit 0; pairs 00 and 11 are discarded.
  - The pair phase resets on reset and on a request clear.
  - Pairing pauses while full.
- **`VON_NEUMANN_EN` undefined:** every sample is accepted directly, as described above.

## Structure

- **Package `trng_pkg`:**
  - `VEC_W`=8 and `SYNC_STAGES`=2.
  - Counter width `$clog2(VEC_W+1)`.
- **Sub-module `ring_osc`:**
  - Ports: `en`, `out`.
  - Built from `STAGES` inverters closed in a loop, with the first stage as a NAND gated by `en`.
  - Each stage carries a unit simulation delay so the loop oscillates in simulation; synthesis ignores the delays.
  - Must be marked keep/dont_touch.
- Collection logic stays in the top module.

## Test plan

- **Reset and warm-up:** hold `rst_n`=0 for 5 clocks → `vector`=0x00, `vector_valid`=0. Release → `vector_valid` still 0 before E10.
- **Basic capture:** `use_ext`=1; drive `ext_bit` 1,0,1,1,0,0,1,0 so they are accepted at E3..E10 → `vector`=0xB2 and `vector_valid`=1 after E10.
- **Hold while full:** keep toggling `ext_bit` with no `req` → `vector` stays 0xB2.
- **Consume:**
  - Raise `req` → `vector_valid` falls 2 edges later, `vector` still 0xB2.
  - Next 8 bits of all ones → `vector`=0xFF.
- **Ignored request:** `req` edge while `vector_valid`=0, or coinciding with completion → no state change.
- **Debias (`VON_NEUMANN_EN`):** feed pairs 10,00,01,11,10,10,01,01,10,01 → `vector`=0xB2 after the 10th pair.
- **Oscillator path:** `use_ext`=0 → `ring_osc` output toggles, and a vector completes in simulation at E10.
